// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem read at a time feeding a BUF_DEPTH entry instruction buffer.
// Head is visible the cycle after rvalid and stalls on inst_ready low. IF_ALIGN_CHECK_EN adds a sticky misaligned-redirect fault.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        setPc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_from_PC,
    output logic        fetch_fault
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
    state_t state, state_nxt;

    logic [31:0]      fetch_pc;
    logic [31:0]      buf_inst [BUF_DEPTH];
    logic [31:0]      buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic             flush, push, pop, issue;
    logic [31:0]      redir_tgt, flush_pc;

`ifdef IF_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fault_q <= 1'b0;
        end else if (setPc) begin
            fault_q <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            fault_q <= 1'b1;
        end
    end

    assign fetch_fault = fault_q;
    assign redir_tgt   = redirect_pc;
`else
    assign fetch_fault = 1'b0;
    assign redir_tgt   = redirect_pc & 32'hFFFF_FFFC;
`endif

    // setPc is a redirect to the boot address and wins over a simultaneous redirect
    assign flush    = setPc || redirect;
    assign flush_pc = setPc ? RESET_PC : redir_tgt;
    assign push     = (state == WAIT) && imem_rvalid && !flush;
    assign pop      = inst_valid && inst_ready;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        imem_req  = 1'b0;
        case (state)
            IDLE: begin
                issue    = clrn && !flush && !fetch_fault && (count < DEPTH_C);
                imem_req = issue;
                if (issue) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                end else if (flush) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (flush) begin
                fetch_pc <= flush_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // fetch_pc only moves in WAIT on a flush, which suppresses the push, so it still points one past the request
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_inst[i] <= '0;
                buf_pc[i]   <= RESET_PC;
            end
        end else if (push) begin
            buf_inst[tail] <= imem_rdata;
            buf_pc[tail]   <= fetch_pc - 32'd4;
        end
    end

    assign imem_addr   = fetch_pc;
    assign inst_valid  = (count != '0);
    assign instruction = buf_inst[head];
    assign pc_from_PC  = buf_pc[head];

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: queue-based reference model, per-cycle compare, directed scenarios then random traffic.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        clrn, setPc, redirect, imem_rvalid, inst_ready;
    logic [31:0] redirect_pc, imem_rdata, imem_addr, instruction, pc_from_PC;
    logic        imem_req, inst_valid, fetch_fault;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk), .clrn(clrn), .setPc(setPc), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
        .pc_from_PC(pc_from_PC), .fetch_fault(fetch_fault)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat_min = 1;
    int lat_max = 1;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    mreq_t       mq[$];
    ent_t        m_q[$];
    logic [31:0] m_pc, m_out_addr;
    int          m_out;   // 0 nothing pending, 1 live request, 2 stale request
    logic        m_fault;
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h3C5A_9600;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        return (i < pop_log.size()) ? pop_log[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_q.delete();
        m_out   = 0;
        m_fault = 1'b0;
    endtask

    task automatic step();
        logic        exp_req, flush, rv;
        logic [31:0] rd;
        rv = 1'b0;
        rd = $urandom;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rv = 1'b1;
            rd = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        imem_rvalid = rv;
        imem_rdata  = rd;
        if (!clrn) model_reset();
        @(negedge clk);
        exp_req = clrn && (m_out == 0) && (m_q.size() < BUF_DEPTH) && !setPc && !redirect && !m_fault;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("instruction", instruction, m_q[0].inst);
            chk("pc_from_PC", pc_from_PC, m_q[0].pc);
        end
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        if (!clrn) begin
            chk("rst_instruction", instruction, 32'h0);
            chk("rst_pc_from_PC", pc_from_PC, RESET_PC);
        end
        if (imem_req && clrn) begin
            req_log.push_back(imem_addr);
            mq.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
        end
        if (inst_valid && inst_ready) pop_log.push_back(pc_from_PC);
        if (clrn) begin
            flush = setPc || redirect;
            if (flush) begin
                m_q.delete();
            end else begin
                if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
                if (m_out == 1 && rv) m_q.push_back('{inst: mem_word(m_out_addr), pc: m_out_addr});
            end
            if (m_out != 0 && rv) m_out = 0;
            else if (m_out == 1 && flush) m_out = 2;
            if (exp_req) begin
                m_out      = 1;
                m_out_addr = m_pc;
                m_pc       = m_pc + 32'd4;
            end
            if (setPc) begin
                m_pc    = RESET_PC;
                m_fault = 1'b0;
            end else if (redirect) begin
`ifdef IF_ALIGN_CHECK_EN
                m_pc = redirect_pc;
                if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
`else
                m_pc = {redirect_pc[31:2], 2'b00};
`endif
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int r;
        clrn = 1'b0; setPc = 1'b0; redirect = 1'b0; redirect_pc = '0;
        inst_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        model_reset();
        step();
        step();

        // boot through setPc with a 1-cycle memory and an always-ready consumer
        clrn = 1'b1; setPc = 1'b1;
        step();
        setPc = 1'b0; inst_ready = 1'b1;
        req_log.delete(); pop_log.delete();
        repeat (10) step();
        chk("boot_req0", req_at(0), 32'h0);
        chk("boot_req1", req_at(1), 32'h4);
        chk("boot_req2", req_at(2), 32'h8);
        chk("boot_pc0", pop_at(0), 32'h0);
        chk("boot_pc1", pop_at(1), 32'h4);
        chk("boot_pc2", pop_at(2), 32'h8);

        // stalled consumer: buffer fills and requests stop
        setPc = 1'b1;
        step();
        setPc = 1'b0; inst_ready = 1'b0;
        req_log.delete();
        repeat (10) step();
        chk("stall_req_count", 32'(req_log.size()), 32'(BUF_DEPTH));
        chk("stall_req_low", 32'(imem_req), 32'h0);
        chk("stall_head_pc", pc_from_PC, RESET_PC);
        chk("stall_head_inst", instruction, mem_word(RESET_PC));

        // redirect while a 3-cycle read is outstanding
        inst_ready = 1'b1; setPc = 1'b1;
        step();
        setPc = 1'b0; lat_min = 3; lat_max = 3;
        step();
        step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        req_log.delete(); pop_log.delete();
        repeat (12) step();
        chk("redir_req0", req_at(0), 32'h100);
        chk("redir_pc0", pop_at(0), 32'h100);

        // fetch address wraps at the top of the address space
        lat_min = 1; lat_max = 1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        req_log.delete();
        repeat (8) step();
        chk("wrap_req0", req_at(0), 32'hFFFF_FFFC);
        chk("wrap_req1", req_at(1), 32'h0);

        // misaligned redirect target
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        req_log.delete();
        repeat (8) step();
`ifdef IF_ALIGN_CHECK_EN
        chk("misalign_fault", 32'(fetch_fault), 32'h1);
        chk("misalign_no_req", 32'(req_log.size()), 32'h0);
`else
        chk("misalign_req0", req_at(0), 32'h100);
        chk("misalign_fault", 32'(fetch_fault), 32'h0);
`endif

        // reset in the middle of a read; the late response must be ignored
        setPc = 1'b1;
        repeat (3) step();
        setPc = 1'b0; lat_min = 4; lat_max = 4;
        step();
        step();
        clrn = 1'b0;
        step();
        clrn = 1'b1; setPc = 1'b1; lat_min = 1; lat_max = 1;
        step();
        step();
        setPc = 1'b0;
        req_log.delete(); pop_log.delete();
        repeat (10) step();
        chk("rst_mid_req0", req_at(0), RESET_PC);
        chk("rst_mid_pc0", pop_at(0), RESET_PC);

        // random traffic
        lat_min = 1; lat_max = 4;
        repeat (3000) begin
            r = int'($urandom_range(999, 0));
            clrn = 1'b1; setPc = 1'b0; redirect = 1'b0;
            if (r < 5) begin
                clrn = 1'b0;
                mq.delete();
            end else if (r < 25) begin
                setPc = 1'b1;
            end else if (r < 80) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
                if ($urandom_range(3, 0) != 0) redirect_pc[1:0] = 2'b00;
            end
            inst_ready = ($urandom_range(9, 0) < 7);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, boot address loaded while setPc is high.
REQ-002 Parameter BUF_DEPTH, default 2, number of entries in the fetched-instruction buffer (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 setPc  input  1  synchronous PC preset: fetch PC := RESET_PC, buffer flushed.
REQ-006 redirect  input  1  taken branch/jump from the execute stage.
REQ-007 redirect_pc  input  32  target address, valid when redirect is high.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  32  word-aligned read address, valid with imem_req.
REQ-010 imem_rvalid  input  1  read data valid; one response per accepted request, latency >=1 cycle, unbounded.
REQ-011 imem_rdata  input  32  read data.
REQ-012 inst_valid  output  1  buffer head holds an instruction.
REQ-013 inst_ready  input  1  consumer accepts the head this cycle.
REQ-014 instruction  output  32  head instruction word.
REQ-015 pc_from_PC  output  32  address of the head instruction.
REQ-016 fetch_fault  output  1  misaligned-target flag (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE (no request outstanding), WAIT (one request outstanding), and DISCARD (one stale request outstanding after a flush).
REQ-018 At most one request SHALL be outstanding; imem_req is a one-cycle pulse, issued only in IDLE with free buffer slots > 0, setPc low, redirect low, and fetch_fault low.
REQ-019 On issue: imem_addr = fetch PC, fetch PC += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), state IDLE -> WAIT.
REQ-020 In WAIT, imem_rvalid SHALL push {imem_rdata, request address} into the buffer, state -> IDLE; a new request may issue in the next cycle at the earliest.
REQ-021 Handshake: the head is popped when inst_valid and inst_ready are both high; instruction and pc_from_PC are stable while inst_valid is high and inst_ready is low.
REQ-022 Push and pop in the same cycle SHALL both occur, with occupancy unchanged; a push into a full buffer SHALL never happen (guaranteed by REQ-018).
REQ-023 redirect high SHALL flush the buffer (inst_valid low next cycle), set fetch PC := redirect_pc, and discard any same-cycle imem_rvalid data.
REQ-024 If redirect arrives in WAIT without imem_rvalid the same cycle, state -> DISCARD; the next imem_rvalid is dropped, then state -> IDLE.
REQ-025 setPc SHALL act like a redirect to RESET_PC, including the DISCARD rule; if setPc and redirect are both high, setPc wins.
REQ-026 Redirect latency: the first request to redirect_pc SHALL issue no earlier than 1 cycle after redirect (IDLE case); the first instruction from redirect_pc SHALL be visible no earlier than 2 cycles after redirect.
REQ-027 A pop in the same cycle as a flush SHALL be honoured by the consumer, but the flush takes priority on the buffer contents.

Reset
REQ-028 When clrn is low, the block SHALL asynchronously set: state = IDLE, fetch PC = RESET_PC, buffer empty, imem_req = 0, inst_valid = 0, instruction = 0, pc_from_PC = RESET_PC, fetch_fault = 0.
REQ-029 If clrn is asserted in WAIT/DISCARD, the outstanding response arriving after reset SHALL be ignored (state IDLE consumes no rvalid).
REQ-030 The first request after clrn release SHALL issue on the first rising edge with clrn high and setPc low.

Configuration
REQ-031 Macro IF_ALIGN_CHECK_EN defined: a redirect_pc with bits[1:0] != 0 SHALL set fetch_fault (sticky until reset or setPc) and inhibit further requests; the buffer is still flushed.
REQ-032 Macro IF_ALIGN_CHECK_EN undefined: redirect_pc[1:0] SHALL be forced to 0 and fetch_fault tied to 0.

Verification
REQ-033 Reset, then setPc for 1 cycle with 1-cycle memory and inst_ready=1 -> addresses 0,4,8 are requested and pc_from_PC is 0,4,8 on successive valid heads.
REQ-034 inst_ready=0 for 10 cycles -> exactly BUF_DEPTH (2) requests issued, imem_req stays 0 afterwards, and the head is unchanged.
REQ-035 3-cycle memory latency with redirect to 32'h100 during WAIT -> the stale response is dropped, the next request address is 32'h100, and no stale instruction becomes valid.
REQ-036 fetch PC 32'hFFFF_FFFC -> the next request address is 32'h0000_0000.
REQ-037 redirect_pc=32'h102 -> with IF_ALIGN_CHECK_EN, fetch_fault=1 and no further imem_req; without it, the request address is 32'h100.
REQ-038 clrn pulsed low mid-WAIT, memory returns rvalid 2 cycles later -> the response is ignored and the fetch restarts at RESET_PC.
